// File: rtl/dequeue_agent.sv
// Egress dequeue agent: per-port PIFO pop and chunk streaming FSMs
// with saturating statistics readable over the CPU request channel.
module dequeue_agent #(
  parameter int NUM_PORTS      = 5,
  parameter int CNT_W          = 32,
  parameter int TIMEOUT_CYCLES = 255
) (
  input  logic                 axis_aclk,
  input  logic                 axis_reset,
  input  logic [NUM_PORTS-1:0] s_axis_pifo_empty,
  input  logic [NUM_PORTS-1:0] s_axis_buffer_empty,
  input  logic [NUM_PORTS-1:0] s_axis_buffer_tlast,
  input  logic [NUM_PORTS-1:0] s_axis_port_pause,
  output logic [NUM_PORTS-1:0] m_axis_ctl_pifo_out_en,
  output logic [NUM_PORTS-1:0] m_axis_ctl_buffer_rd_en,
  output logic [NUM_PORTS-1:0] m_axis_tvalid,
  input  logic [NUM_PORTS-1:0] m_axis_tready,
  input  logic [7:0]           s_axi_addr,
  input  logic                 s_axi_req_valid,
  output logic [31:0]          m_axi_data,
  output logic                 m_axi_resp_valid
);

  localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [TW-1:0] T_LAST = TW'(TIMEOUT_CYCLES - 1);
  localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};

  typedef enum logic [1:0] {
    IDLE,
    POP,
    STREAM,
    GAP
  } state_t;

  state_t            state_q [NUM_PORTS];
  state_t            state_d [NUM_PORTS];
  logic [TW-1:0]     timer_q [NUM_PORTS];
  logic [TW-1:0]     timer_d [NUM_PORTS];
  logic [CNT_W-1:0]  pkt_cnt [NUM_PORTS];
  logic [CNT_W-1:0]  chk_cnt [NUM_PORTS];
  logic [CNT_W-1:0]  unr_cnt [NUM_PORTS];

  logic [NUM_PORTS-1:0] pkt_inc;
  logic [NUM_PORTS-1:0] chk_inc;
  logic [NUM_PORTS-1:0] unr_inc;
  logic [31:0]          rd_val;

  always_ff @(posedge axis_aclk) begin
    if (axis_reset) begin
      for (int i = 0; i < NUM_PORTS; i++) begin
        state_q[i] <= IDLE;
        timer_q[i] <= '0;
      end
    end else begin
      for (int i = 0; i < NUM_PORTS; i++) begin
        state_q[i] <= state_d[i];
        timer_q[i] <= timer_d[i];
      end
    end
  end

  always_comb begin
    m_axis_ctl_pifo_out_en  = '0;
    m_axis_ctl_buffer_rd_en = '0;
    m_axis_tvalid           = '0;
    pkt_inc                 = '0;
    chk_inc                 = '0;
    unr_inc                 = '0;
    for (int i = 0; i < NUM_PORTS; i++) begin
      state_d[i] = state_q[i];
      timer_d[i] = timer_q[i];
      unique case (state_q[i])
        IDLE: begin
          if (!s_axis_pifo_empty[i] &&
              !s_axis_buffer_empty[i] &&
              !s_axis_port_pause[i])
            state_d[i] = POP;
        end
        POP: begin
          m_axis_ctl_pifo_out_en[i] = 1'b1;
          timer_d[i] = '0;
          state_d[i] = STREAM;
        end
        STREAM: begin
          m_axis_tvalid[i] = !s_axis_buffer_empty[i];
          m_axis_ctl_buffer_rd_en[i] =
            !s_axis_buffer_empty[i] & m_axis_tready[i];
          if (m_axis_ctl_buffer_rd_en[i]) begin
            chk_inc[i] = 1'b1;
            timer_d[i] = '0;
            if (s_axis_buffer_tlast[i]) begin
              pkt_inc[i] = 1'b1;
              state_d[i] = GAP;
            end
          end else if (s_axis_buffer_empty[i]) begin
            // this cycle is the TIMEOUT_CYCLES-th empty one in a row
            if (timer_q[i] == T_LAST) begin
              unr_inc[i] = 1'b1;
              timer_d[i] = '0;
              state_d[i] = IDLE;
            end else begin
              timer_d[i] = timer_q[i] + TW'(1);
            end
          end else begin
            timer_d[i] = '0;
          end
        end
        GAP: state_d[i] = IDLE;
        default: state_d[i] = IDLE;
      endcase
    end
  end

  always_ff @(posedge axis_aclk) begin
    if (axis_reset) begin
      for (int i = 0; i < NUM_PORTS; i++) begin
        pkt_cnt[i] <= '0;
        chk_cnt[i] <= '0;
        unr_cnt[i] <= '0;
      end
    end else begin
      for (int i = 0; i < NUM_PORTS; i++) begin
        if (pkt_inc[i] && pkt_cnt[i] != CNT_MAX)
          pkt_cnt[i] <= pkt_cnt[i] + CNT_W'(1);
        if (chk_inc[i] && chk_cnt[i] != CNT_MAX)
          chk_cnt[i] <= chk_cnt[i] + CNT_W'(1);
        if (unr_inc[i] && unr_cnt[i] != CNT_MAX)
          unr_cnt[i] <= unr_cnt[i] + CNT_W'(1);
      end
    end
  end

  // counters are sampled before this edge's increment lands
  always_comb begin
    rd_val = '0;
    for (int i = 0; i < NUM_PORTS; i++) begin
      if (s_axi_addr[3:0] == 4'(i)) begin
        case (s_axi_addr[7:4])
          4'd0:    rd_val = 32'(pkt_cnt[i]);
          4'd1:    rd_val = 32'(chk_cnt[i]);
          4'd2:    rd_val = 32'(unr_cnt[i]);
          default: rd_val = '0;
        endcase
      end
    end
  end

  always_ff @(posedge axis_aclk) begin
    if (axis_reset) begin
      m_axi_data       <= '0;
      m_axi_resp_valid <= 1'b0;
    end else begin
      m_axi_resp_valid <= s_axi_req_valid;
      if (s_axi_req_valid)
        m_axi_data <= rd_val;
    end
  end

endmodule

// File: tb/tb_dequeue_agent.sv
// Directed bench for dequeue_agent: a PIFO/buffer model drives the
// ports, per-cycle pop/read histories are compared to hand masks.
module tb_dequeue_agent;

  localparam int NP = 5;

  logic          clk = 1'b0;
  logic          axis_reset;
  logic [NP-1:0] pifo_empty;
  logic [NP-1:0] buf_empty;
  logic [NP-1:0] buf_tlast;
  logic [NP-1:0] pause;
  logic [NP-1:0] pop_en;
  logic [NP-1:0] rd_en;
  logic [NP-1:0] tvalid;
  logic [NP-1:0] tready;
  logic [7:0]    addr;
  logic          req;
  logic [31:0]   data;
  logic          resp;

  int            pq [NP];
  int            pk_left [NP];
  int            pk_next [NP];
  logic [NP-1:0] hold;

  logic [31:0]   pop_hist [NP];
  logic [31:0]   rd_hist [NP];
  logic [NP-1:0] s_pop;
  logic [NP-1:0] s_rd;
  logic [NP-1:0] s_tv;
  int            cyc;
  int            n_checks = 0;
  int            n_errors = 0;

  always #5 clk = ~clk;

  dequeue_agent dut (
    .axis_aclk               (clk),
    .axis_reset              (axis_reset),
    .s_axis_pifo_empty       (pifo_empty),
    .s_axis_buffer_empty     (buf_empty),
    .s_axis_buffer_tlast     (buf_tlast),
    .s_axis_port_pause       (pause),
    .m_axis_ctl_pifo_out_en  (pop_en),
    .m_axis_ctl_buffer_rd_en (rd_en),
    .m_axis_tvalid           (tvalid),
    .m_axis_tready           (tready),
    .s_axi_addr              (addr),
    .s_axi_req_valid         (req),
    .m_axi_data              (data),
    .m_axi_resp_valid        (resp)
  );

  always_comb begin
    for (int i = 0; i < NP; i++) begin
      pifo_empty[i] = (pq[i] == 0);
      buf_empty[i]  = (pk_left[i] == 0) || hold[i];
      buf_tlast[i]  = (pk_left[i] == 1);
    end
  end

  task automatic check(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic clear_mon();
    cyc = 0;
    for (int i = 0; i < NP; i++) begin
      pop_hist[i] = '0;
      rd_hist[i]  = '0;
    end
  endtask

  // sample mid-cycle, then advance the PIFO/buffer model past the edge
  task automatic tick();
    @(negedge clk);
    s_pop = pop_en;
    s_rd  = rd_en;
    s_tv  = tvalid;
    if (cyc < 32) begin
      for (int i = 0; i < NP; i++) begin
        pop_hist[i][cyc[4:0]] = s_pop[i];
        rd_hist[i][cyc[4:0]]  = s_rd[i];
      end
    end
    @(posedge clk);
    #1;
    cyc++;
    for (int i = 0; i < NP; i++) begin
      if (s_pop[i]) pq[i]--;
      if (s_rd[i]) begin
        if (pk_left[i] == 1) begin
          pk_left[i] = pk_next[i];
          pk_next[i] = 0;
        end else begin
          pk_left[i]--;
        end
      end
    end
  endtask

  task automatic cpu_read(input string tag, input logic [7:0] a,
                          input logic [31:0] exp);
    addr = a;
    req  = 1'b1;
    tick();
    req  = 1'b0;
    check({tag, "_rv"}, {31'b0, resp}, 32'd1);
    check(tag, data, exp);
  endtask

  initial begin
    axis_reset = 1'b1;
    pause  = '0;
    tready = '1;
    hold   = '0;
    addr   = '0;
    req    = 1'b0;
    for (int i = 0; i < NP; i++) begin
      pq[i] = 0;
      pk_left[i] = 0;
      pk_next[i] = 0;
    end
    clear_mon();
    repeat (3) tick();
    check("rst_pop", {27'b0, s_pop}, 32'd0);
    check("rst_rd", {27'b0, s_rd}, 32'd0);
    check("rst_tv", {27'b0, s_tv}, 32'd0);
    check("rst_rv", {31'b0, resp}, 32'd0);
    check("rst_data", data, 32'd0);
    axis_reset = 1'b0;
    tick();

    // port 0: single 3-chunk packet
    clear_mon();
    pq[0] = 1;
    pk_left[0] = 3;
    repeat (8) tick();
    check("p0_pop", pop_hist[0], 32'h2);
    check("p0_rd", rd_hist[0], 32'h1c);
    cpu_read("p0_pkt", 8'h00, 32'd1);
    cpu_read("p0_chk", 8'h10, 32'd3);

    // ports 1..3 concurrently, 2 chunks each
    clear_mon();
    for (int i = 1; i <= 3; i++) begin
      pq[i] = 1;
      pk_left[i] = 2;
    end
    repeat (8) tick();
    for (int i = 1; i <= 3; i++) begin
      check($sformatf("p%0d_pop", i), pop_hist[i], 32'h2);
      check($sformatf("p%0d_rd", i), rd_hist[i], 32'hc);
    end
    check("p4_pop", pop_hist[4], 32'h0);
    cpu_read("p1_pkt", 8'h01, 32'd1);
    cpu_read("p2_pkt", 8'h02, 32'd1);
    cpu_read("p3_pkt", 8'h03, 32'd1);
    cpu_read("p4_pkt", 8'h04, 32'd0);

    // port 2: downstream backpressure mid-packet
    begin
      logic [7:0] pat;
      pat = 8'he7;
      clear_mon();
      pq[2] = 1;
      pk_left[2] = 3;
      for (int k = 0; k < 8; k++) begin
        tready[2] = pat[k];
        tick();
      end
      tready = '1;
      check("bp_pop", pop_hist[2], 32'h2);
      check("bp_rd", rd_hist[2], 32'h64);
      cpu_read("bp_pkt", 8'h02, 32'd2);
      cpu_read("bp_chk", 8'h12, 32'd5);
    end

    // port 3: underrun after first chunk
    pq[3] = 1;
    pk_left[3] = 3;
    repeat (3) tick();
    hold[3] = 1'b1;
    repeat (253) tick();
    cpu_read("unr_early", 8'h23, 32'd0);
    cpu_read("unr_same", 8'h23, 32'd0);
    cpu_read("unr_done", 8'h23, 32'd1);
    cpu_read("unr_pkt", 8'h03, 32'd1);
    cpu_read("unr_chk", 8'h13, 32'd3);
    pk_left[3] = 0;
    hold[3] = 1'b0;

    // port 1: pause during a packet, second packet waits
    clear_mon();
    pq[1] = 2;
    pk_left[1] = 4;
    pk_next[1] = 2;
    for (int k = 0; k < 18; k++) begin
      pause[1] = (k >= 2 && k <= 12);
      tick();
    end
    pause = '0;
    check("pz_pop", pop_hist[1], 32'h4002);
    check("pz_rd", rd_hist[1], 32'h1803c);
    cpu_read("pz_pkt", 8'h01, 32'd3);
    cpu_read("pz_chk", 8'h11, 32'd8);
    cpu_read("sel3", 8'h30, 32'd0);
    cpu_read("port5", 8'h05, 32'd0);

    // reset in the middle of a port 0 packet
    pq[0] = 1;
    pk_left[0] = 5;
    repeat (4) tick();
    axis_reset = 1'b1;
    tick();
    tick();
    check("mr_pop", {27'b0, s_pop}, 32'd0);
    check("mr_rd", {27'b0, s_rd}, 32'd0);
    check("mr_tv", {27'b0, s_tv}, 32'd0);
    check("mr_rv", {31'b0, resp}, 32'd0);
    check("mr_data", data, 32'd0);
    axis_reset = 1'b0;
    pq[0] = 0;
    pk_left[0] = 0;
    tick();
    for (int p = 0; p < NP; p++) begin
      for (int s = 0; s < 3; s++) begin
        cpu_read($sformatf("clr_%0d%0d", s, p),
                 {4'(s), 4'(p)}, 32'd0);
      end
    end
    cpu_read("clr_45", 8'h45, 32'd0);

    $display("Simulation finished: %0d checks, %0d errors",
             n_checks, n_errors);
    $finish;
  end

endmodule
